ffsr_pulse_bank: RTL and testbench

//  - Multi-channel bank of thermometer-coded (pulse-encoded) up/down registers; next generation of the single-channel FFSR.
//  - Adds per-channel load, saturation, overflow flag, shared periodic leak, fire-on-full with optional auto-clear, code checking.
//  - Sits between spike-input logic (inc/dec) and neuron threshold/readout logic; one channel per neuron potential.

---
 rtl/ffsr_pkg.sv | 26 ++
 rtl/ffsr_pulse_ch.sv | 55 +++++
 rtl/ffsr_pulse_bank.sv | 58 +++++
 tb/tb_ffsr_pulse_bank.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ffsr_pkg.sv
// ffsr_pkg: thermometer shift helpers, code check and leak counter sizing
// shared by the pulse bank and its channels.
// Codes are held in descending vectors: value k sets bits [k-1:0], so the
// MSB (q[WIDTH-1]) is the "full" bit and the LSB (q[0]) the "non-empty" bit.
// Helpers work on a wide container; callers zero-extend and truncate.
package ffsr_pkg;
  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] therm_t;
  // +1: shift a one in at the LSB, keep within w bits (saturates at all-ones)
  function automatic therm_t up1(therm_t q, int w);
    return ((q << 1) | therm_t'(1)) & ~(~therm_t'(0) << w);
  endfunction
  function automatic therm_t dn1(therm_t q);
    return q >> 1;
  endfunction
  function automatic therm_t dn2(therm_t q);
    return q >> 2;
  endfunction
  // a valid code is a run of ones from the LSB, so q+1 is a power of two
  function automatic logic is_thermo(therm_t q);
    return (q & (q + therm_t'(1))) == '0;
  endfunction
  function automatic int leak_w(int p);
    return p > 1 ? $clog2(p) : 1;
  endfunction
endpackage

// File: rtl/ffsr_pulse_ch.sv
// ffsr_pulse_ch: one thermometer-coded up/down channel with load, optional
// clear-on-full, saturation and registered fire/ovf pulses.
// Ports: clk, rst (async active-low), load/init (verbatim load), inc/dec
// (step requests), tick (shared leak), q (code), full/empty/code_err
// (combinational from q), fire/ovf (registered 1-cycle pulses).
module ffsr_pulse_ch
  import ffsr_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter bit RESET_ON_FIRE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] init,
  input  logic             inc,
  input  logic             dec,
  input  logic             tick,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty,
  output logic             fire,
  output logic             ovf,
  output logic             code_err
);
  logic [1:0]       m;
  logic             clr;
  logic [WIDTH-1:0] shifted, nxt;
  logic             fire_n, ovf_n;
  assign full     = q[WIDTH-1];
  assign empty    = ~q[0];
  assign code_err = ~is_thermo(therm_t'(q));
  // m = dec + tick - inc modulo 4: 3 means +1, 1 means -1, 2 means -2, 0 hold
  always_comb begin
    m       = {1'b0, dec} + {1'b0, tick} - {1'b0, inc};
    clr     = RESET_ON_FIRE && full;
    shifted = m == 2'd3 ? WIDTH'(up1(therm_t'(q), WIDTH)) :
              m == 2'd1 ? WIDTH'(dn1(therm_t'(q))) :
              m == 2'd2 ? WIDTH'(dn2(therm_t'(q))) : q;
    nxt     = load ? init : clr ? '0 : shifted;
    fire_n  = load ? (&init && !full) : (!clr && shifted[WIDTH-1] && !full);
    ovf_n   = !load && !clr && m == 2'd3 && full;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= '0;
      fire <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      q    <= nxt;
      fire <= fire_n;
      ovf  <= ovf_n;
    end
  end
endmodule

// File: rtl/ffsr_pulse_bank.sv
// ffsr_pulse_bank: NUM_CH thermometer up/down channels sharing one periodic
// leak timer.
// Ports: clk, rst (async active-low), load/init/inc/dec per channel,
// leak_en (runs the leak timer), out (codes, channel c at [c*WIDTH +: WIDTH]),
// full/empty/code_err (combinational), fire/ovf (registered pulses).
module ffsr_pulse_bank
  import ffsr_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int NUM_CH        = 4,
  parameter int LEAK_PERIOD   = 16,
  parameter bit RESET_ON_FIRE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] init,
  input  logic [NUM_CH-1:0]       inc,
  input  logic [NUM_CH-1:0]       dec,
  input  logic                    leak_en,
  output logic [NUM_CH*WIDTH-1:0] out,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       empty,
  output logic [NUM_CH-1:0]       fire,
  output logic [NUM_CH-1:0]       ovf,
  output logic [NUM_CH-1:0]       code_err
);
  localparam int            CW   = leak_w(LEAK_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(LEAK_PERIOD > 0 ? LEAK_PERIOD - 1 : 0);
  logic [CW-1:0] cnt;
  logic          tick;
  // period 0 never ticks; period 1 ticks every enabled cycle (LAST = 0)
  assign tick = LEAK_PERIOD != 0 && leak_en && cnt == LAST;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= (!leak_en || tick) ? '0 : cnt + CW'(1);
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ffsr_pulse_ch #(
      .WIDTH(WIDTH),
      .RESET_ON_FIRE(RESET_ON_FIRE)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .load(load[c]),
      .init(init[c*WIDTH +: WIDTH]),
      .inc(inc[c]),
      .dec(dec[c]),
      .tick(tick),
      .q(out[c*WIDTH +: WIDTH]),
      .full(full[c]),
      .empty(empty[c]),
      .fire(fire[c]),
      .ovf(ovf[c]),
      .code_err(code_err[c])
    );
  end
endmodule

// File: tb/tb_ffsr_pulse_bank.sv
// tb_ffsr_pulse_bank: directed vectors, multi-cycle corner sequences and a
// randomized run against an integer-valued model of the pulse bank.
module tb_ffsr_pulse_bank;
  localparam int W = 8, N = 4, LP = 4;
  logic clk = 0, rst = 1, leak_en = 0;
  logic [N-1:0] load = '0, inc = '0, dec = '0;
  logic [N*W-1:0] init = '0, out_a, out_b;
  logic [N-1:0] full_a, empty_a, fire_a, ovf_a, err_a;
  logic [N-1:0] full_b, empty_b, fire_b, ovf_b, err_b;
  int total = 0, bad = 0;
  typedef struct {
    logic       ld;
    logic [7:0] ini;
    logic       up;
    logic       dn;
    logic [7:0] q;
    logic       f;
    logic       o;
    logic       e;
  } vec_t;
  vec_t tbl[20];
  always #5 clk = ~clk;
  ffsr_pulse_bank #(.WIDTH(W), .NUM_CH(N), .LEAK_PERIOD(LP), .RESET_ON_FIRE(0)) dut_a (
    .clk(clk), .rst(rst), .load(load), .init(init), .inc(inc), .dec(dec), .leak_en(leak_en),
    .out(out_a), .full(full_a), .empty(empty_a), .fire(fire_a), .ovf(ovf_a), .code_err(err_a));
  ffsr_pulse_bank #(.WIDTH(W), .NUM_CH(N), .LEAK_PERIOD(LP), .RESET_ON_FIRE(1)) dut_b (
    .clk(clk), .rst(rst), .load(load), .init(init), .inc(inc), .dec(dec), .leak_en(leak_en),
    .out(out_b), .full(full_b), .empty(empty_b), .fire(fire_b), .ovf(ovf_b), .code_err(err_b));
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(int n);
    load = '0;
    inc  = '0;
    dec  = '0;
    repeat (n) step();
  endtask
  function automatic logic [W-1:0] th(int k);
    logic [15:0] one = 16'd1;
    return W'((one << k) - 16'd1);
  endfunction
  // value-level model of one channel for one edge
  task automatic model(inout int v, input bit rof, ld, up, dn, tk, input int iv, output bit f, o);
    int d, s;
    f = 0;
    o = 0;
    if (ld) begin
      f = iv == W && v != W;
      v = iv;
    end else if (rof && v == W) begin
      v = 0;
    end else begin
      d = int'(up) - int'(dn) - int'(tk);
      s = v + d;
      o = v == W && d == 1;
      f = v != W && s >= W;
      v = s < 0 ? 0 : s > W ? W : s;
    end
  endtask
  initial begin
    int va[N], vb[N], iv[N], cnt, lv;
    bit tk, fa, oa, fb, ob;
    logic [N*W-1:0] eq_a, eq_b;
    logic [N-1:0] ef_a, eo_a, eu_a, ee_a, ef_b, eo_b, eu_b, ee_b;
    // asynchronous reset, held across an edge
    #1 rst = 0;
    #1;
    chk("rst_out_a", 64'(out_a), 64'd0);
    chk("rst_out_b", 64'(out_b), 64'd0);
    chk("rst_fire", 64'(fire_a), 64'd0);
    step();
    chk("rst_hold", 64'(out_a), 64'd0);
    rst = 1;
    load = 4'b0111;
    init = {8'h00, 8'hFF, 8'h7F, 8'h3F};
    step();
    chk("ld_all", 64'(out_a), 64'h00FF7F3F);
    load = '0;
    inc = 4'b0110;
    step();
    chk("sat_out", 64'(out_a), 64'h00FFFF3F);
    chk("fire_ch1", 64'(fire_a), 64'h2);
    chk("ovf_ch2", 64'(ovf_a), 64'h4);
    inc = '0;
    #2 rst = 0;
    #1;
    chk("arst_out", 64'(out_a), 64'd0);
    chk("arst_fire", 64'(fire_a), 64'd0);
    chk("arst_ovf", 64'(ovf_a), 64'd0);
    load = '1;
    inc = '1;
    init = '1;
    step();
    chk("arst_hold", 64'(out_a), 64'd0);
    load = '0;
    inc = '0;
    init = '0;
    rst = 1;
    // channel 0 vectors, no leak, RESET_ON_FIRE=0
    tbl[0]  = '{1'b1, 8'h07, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'h7F, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 8'h50, 1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b1};
    tbl[19] = '{1'b1, 8'h0F, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0};
    foreach (tbl[i]) begin
      load = {3'b0, tbl[i].ld};
      init = {24'h0, tbl[i].ini};
      inc  = {3'b0, tbl[i].up};
      dec  = {3'b0, tbl[i].dn};
      step();
      chk($sformatf("vec%0d_q", i), 64'(out_a[7:0]), 64'(tbl[i].q));
      chk($sformatf("vec%0d_fire", i), 64'(fire_a[0]), 64'(tbl[i].f));
      chk($sformatf("vec%0d_ovf", i), 64'(ovf_a[0]), 64'(tbl[i].o));
      chk($sformatf("vec%0d_err", i), 64'(err_a[0]), 64'(tbl[i].e));
    end
    // fire with clear-on-full (dut_b)
    load = 4'b0001;
    init = {24'h0, 8'h7F};
    inc = '0;
    dec = '0;
    step();
    chk("rof_ld", 64'(out_b[7:0]), 64'h7F);
    load = '0;
    inc = 4'b0001;
    step();
    chk("rof_full", 64'(out_b[7:0]), 64'hFF);
    chk("rof_fire", 64'(fire_b[0]), 64'd1);
    chk("rof_fullf", 64'(full_b[0]), 64'd1);
    step();
    chk("rof_clr", 64'(out_b[7:0]), 64'h00);
    chk("rof_fire0", 64'(fire_b[0]), 64'd0);
    chk("rof_ovf0", 64'(ovf_b[0]), 64'd0);
    chk("rof_full0", 64'(full_b[0]), 64'd0);
    // simultaneous events against the leak tick (dut_a ch0)
    load = 4'b0001;
    init = {24'h0, 8'h07};
    inc = '0;
    leak_en = 1;
    step();
    idle(2);
    chk("tk_pre", 64'(out_a[7:0]), 64'h07);
    inc = 4'b0001;
    dec = 4'b0001;
    step();
    chk("tk_incdec", 64'(out_a[7:0]), 64'h03);
    idle(3);
    chk("tk_wait", 64'(out_a[7:0]), 64'h03);
    load = 4'b0001;
    inc = 4'b0001;
    step();
    chk("tk_ldwin", 64'(out_a[7:0]), 64'h07);
    idle(3);
    dec = 4'b0001;
    step();
    chk("tk_dec2", 64'(out_a[7:0]), 64'h01);
    inc = 4'b0001;
    dec = 4'b0001;
    step();
    chk("notk_hold", 64'(out_a[7:0]), 64'h01);
    idle(2);
    inc = 4'b0001;
    step();
    chk("tk_inc_hold", 64'(out_a[7:0]), 64'h01);
    inc = '0;
    leak_en = 0;
    // leak from 5 down to 0 on ch2
    load = 4'b0100;
    init = {8'h00, 8'h1F, 16'h0};
    step();
    load = '0;
    leak_en = 1;
    for (int k = 1; k <= 24; k++) begin
      step();
      lv = 5 - k / 4;
      chk($sformatf("leak%0d", k), 64'(out_a[23:16]), 64'(th(lv < 0 ? 0 : lv)));
    end
    load = 4'b0100;
    step();
    load = '0;
    step();
    leak_en = 0;
    step();
    leak_en = 1;
    step();
    step();
    step();
    chk("leak_restart", 64'(out_a[23:16]), 64'h1F);
    step();
    chk("leak_tick", 64'(out_a[23:16]), 64'h0F);
    // randomized run against the model
    leak_en = 0;
    idle(1);
    rst = 0;
    step();
    rst = 1;
    cnt = 0;
    for (int c = 0; c < N; c++) begin
      va[c] = 0;
      vb[c] = 0;
    end
    for (int t = 0; t < 600; t++) begin
      leak_en = $urandom_range(9) != 0;
      for (int c = 0; c < N; c++) begin
        iv[c] = int'($urandom_range(W));
        load[c] = $urandom_range(7) == 0;
        inc[c] = $urandom_range(1) == 1;
        dec[c] = $urandom_range(2) == 0;
        init[c*W +: W] = th(iv[c]);
      end
      tk = leak_en && cnt == LP - 1;
      cnt = (!leak_en || tk) ? 0 : cnt + 1;
      for (int c = 0; c < N; c++) begin
        model(va[c], 1'b0, load[c], inc[c], dec[c], tk, iv[c], fa, oa);
        model(vb[c], 1'b1, load[c], inc[c], dec[c], tk, iv[c], fb, ob);
        eq_a[c*W +: W] = th(va[c]);
        eq_b[c*W +: W] = th(vb[c]);
        ef_a[c] = fa;
        eo_a[c] = oa;
        ef_b[c] = fb;
        eo_b[c] = ob;
        eu_a[c] = va[c] == W;
        ee_a[c] = va[c] == 0;
        eu_b[c] = vb[c] == W;
        ee_b[c] = vb[c] == 0;
      end
      step();
      chk($sformatf("rnd%0d_out_a", t), 64'(out_a), 64'(eq_a));
      chk($sformatf("rnd%0d_out_b", t), 64'(out_b), 64'(eq_b));
      chk($sformatf("rnd%0d_fire_a", t), 64'(fire_a), 64'(ef_a));
      chk($sformatf("rnd%0d_fire_b", t), 64'(fire_b), 64'(ef_b));
      chk($sformatf("rnd%0d_ovf_a", t), 64'(ovf_a), 64'(eo_a));
      chk($sformatf("rnd%0d_ovf_b", t), 64'(ovf_b), 64'(eo_b));
      chk($sformatf("rnd%0d_full_a", t), 64'(full_a), 64'(eu_a));
      chk($sformatf("rnd%0d_full_b", t), 64'(full_b), 64'(eu_b));
      chk($sformatf("rnd%0d_empty_a", t), 64'(empty_a), 64'(ee_a));
      chk($sformatf("rnd%0d_empty_b", t), 64'(empty_b), 64'(ee_b));
      chk($sformatf("rnd%0d_err_a", t), 64'(err_a), 64'd0);
      chk($sformatf("rnd%0d_err_b", t), 64'(err_b), 64'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
